// File: rtl/vdc_host_loader.sv
// vdc_host_loader: bus initiator that streams a block of bytes into VDC RAM
// through the register port (R18/R19 update address, R31 data), polling the
// status ready bit (bit 7) before every data-register access.
// Optional build macro: VDC_HOST_LOADER_VERIFY_EN adds a read-back pass that
// compares VDC RAM against a replay of the source stream.
module vdc_host_loader #(
   parameter int POLL_MAX = 255,
   parameter int LEN_BITS = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                bus_en,
   output logic                vdc_cs,
   output logic                vdc_rs,
   output logic                vdc_we,
   output logic [7:0]          vdc_do,
   input  logic [7:0]          vdc_di,
   input  logic                start,
   input  logic [15:0]         start_addr,
   input  logic [LEN_BITS-1:0] len,
   input  logic                s_valid,
   input  logic [7:0]          s_data,
   output logic                s_ready,
   output logic                busy,
   output logic                done,
   output logic                error,
   output logic [15:0]         err_addr
);

   localparam int PW = (POLL_MAX < 2) ? 1 : $clog2(POLL_MAX);

   typedef enum logic [2:0] {S_IDLE, S_SEL, S_POLL, S_WR, S_RD, S_FIN} state_t;
   typedef enum logic [1:0] {PH_HI, PH_LO, PH_DATA} phase_t;

   // VDC register number selected at the start of each phase
   function automatic logic [7:0] sel_reg(input phase_t ph);
      case (ph)
         PH_HI:   sel_reg = 8'd18;
         PH_LO:   sel_reg = 8'd19;
         default: sel_reg = 8'd31;
      endcase
   endfunction

   state_t              state_q, state_d, ret_q, ret_d;
   phase_t              phase_q, phase_d;
   logic [15:0]         addr_q, addr_d, err_addr_q, err_addr_d;
   logic [LEN_BITS-1:0] cnt_q, cnt_d;
   logic [PW-1:0]       poll_q, poll_d;
   logic                cs_q, cs_d, rs_q, rs_d, we_q, we_d;
   logic [7:0]          dout_q, dout_d;
   logic                busy_q, busy_d, done_q, done_d, error_q, error_d;
   logic                go_sel_s, go_poll_s, go_data_s, go_fin_s, byte_done_s;
   logic                vfy_s;

`ifdef VDC_HOST_LOADER_VERIFY_EN
   logic                vfy_q, vfy_d;
   logic [7:0]          shadow_q, shadow_d;
   logic [15:0]         base_q, base_d;
   logic [LEN_BITS-1:0] blen_q, blen_d;
   assign vfy_s = vfy_q;
`else
   logic                unused_s;
   assign vfy_s    = 1'b0;
   assign unused_s = &{1'b0, vdc_di[6:0]};
`endif

   // Next-state and next-slot bus access; one access is committed per bus_en
   always_comb begin
      state_d = state_q;  ret_d = ret_q;  phase_d = phase_q;
      addr_d = addr_q;  cnt_d = cnt_q;  poll_d = poll_q;
      cs_d = cs_q;  rs_d = rs_q;  we_d = we_q;  dout_d = dout_q;
      busy_d = busy_q;  done_d = 1'b0;  error_d = error_q;  err_addr_d = err_addr_q;
      s_ready = 1'b0;
      go_sel_s = 1'b0;  go_poll_s = 1'b0;  go_data_s = 1'b0;
      go_fin_s = 1'b0;  byte_done_s = 1'b0;
`ifdef VDC_HOST_LOADER_VERIFY_EN
      vfy_d = vfy_q;  shadow_d = shadow_q;  base_d = base_q;  blen_d = blen_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               error_d    = 1'b0;
               err_addr_d = 16'h0000;
               if (len != {LEN_BITS{1'b0}}) begin
                  addr_d  = start_addr;
                  cnt_d   = len;
                  busy_d  = 1'b1;
                  phase_d = PH_HI;
                  state_d = S_SEL;
`ifdef VDC_HOST_LOADER_VERIFY_EN
                  vfy_d  = 1'b0;
                  base_d = start_addr;
                  blen_d = len;
`endif
               end else begin
                  done_d = 1'b1;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SEL: begin
            if (bus_en) begin
               if (!cs_q) go_sel_s  = 1'b1;   // first select after start
               else       go_poll_s = 1'b1;   // select finished, poll status
            end else begin
               state_d = S_SEL;
            end
         end
         S_POLL: begin
            if (bus_en) begin
               if (vdc_di[7]) begin
                  if (phase_q == PH_DATA) begin
                     go_data_s = 1'b1;
                  end else begin
                     state_d = S_WR;
                     cs_d = 1'b1;  rs_d = 1'b1;  we_d = 1'b1;
                     dout_d = (phase_q == PH_HI) ? addr_q[15:8] : addr_q[7:0];
                  end
               end else if (poll_q == PW'(POLL_MAX - 1)) begin
                  error_d    = 1'b1;
                  err_addr_d = addr_q;
                  go_fin_s   = 1'b1;
               end else begin
                  poll_d = poll_q + PW'(1);
               end
            end else begin
               state_d = S_POLL;
            end
         end
         S_WR: begin
            if (bus_en) begin
               if (!cs_q) begin
                  go_data_s = 1'b1;            // retry after a stream stall
               end else begin
                  case (phase_q)
                     PH_HI:   begin phase_d = PH_LO;   go_sel_s = 1'b1; end
                     PH_LO:   begin phase_d = PH_DATA; go_sel_s = 1'b1; end
                     default: byte_done_s = 1'b1;
                  endcase
               end
            end else begin
               state_d = S_WR;
            end
         end
         S_RD: begin
`ifdef VDC_HOST_LOADER_VERIFY_EN
            if (bus_en) begin
               if (!cs_q) begin
                  go_data_s = 1'b1;
               end else if (vdc_di != shadow_q) begin
                  error_d    = 1'b1;
                  err_addr_d = addr_q;
                  go_fin_s   = 1'b1;
               end else begin
                  byte_done_s = 1'b1;
               end
            end else begin
               state_d = S_RD;
            end
`else
            go_fin_s = 1'b1;
`endif
         end
         S_FIN: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase

      // A data byte was written (or verified): advance address, wrapping at FFFF
      if (byte_done_s) begin
         addr_d = addr_q + 16'd1;
         cnt_d  = cnt_q - LEN_BITS'(1);
         if (cnt_q == LEN_BITS'(1)) begin
`ifdef VDC_HOST_LOADER_VERIFY_EN
            if (!vfy_q) begin
               vfy_d   = 1'b1;
               addr_d  = base_q;
               cnt_d   = blen_q;
               phase_d = PH_HI;
               go_sel_s = 1'b1;
            end else begin
               go_fin_s = 1'b1;
            end
`else
            go_fin_s = 1'b1;
`endif
         end else begin
            go_poll_s = 1'b1;                  // R31 stays selected
         end
      end else begin
         addr_d = addr_d;
      end

      if (go_sel_s) begin
         state_d = S_SEL;
         cs_d = 1'b1;  rs_d = 1'b0;  we_d = 1'b1;  dout_d = sel_reg(phase_d);
      end else if (go_poll_s) begin
         state_d = S_POLL;
         cs_d = 1'b1;  rs_d = 1'b0;  we_d = 1'b0;  dout_d = 8'h00;
         poll_d = {PW{1'b0}};
         ret_d  = (phase_d == PH_DATA && vfy_s) ? S_RD : S_WR;
      end else if (go_data_s) begin
         state_d = ret_q;
         if (s_valid) begin
            s_ready = 1'b1;
            cs_d = 1'b1;  rs_d = 1'b1;  we_d = (ret_q == S_WR);
            dout_d = (ret_q == S_WR) ? s_data : 8'h00;
`ifdef VDC_HOST_LOADER_VERIFY_EN
            shadow_d = s_data;
`endif
         end else begin
            cs_d = 1'b0;  rs_d = 1'b0;  we_d = 1'b0;  dout_d = 8'h00;
         end
      end else if (go_fin_s) begin
         state_d = S_FIN;
         cs_d = 1'b0;  rs_d = 1'b0;  we_d = 1'b0;  dout_d = 8'h00;
         busy_d = 1'b0;
      end else begin
         cs_d = cs_d;
      end
   end

   // State and registered outputs; synchronous reset aborts any transfer
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;  ret_q <= S_WR;  phase_q <= PH_HI;
         addr_q <= 16'h0000;  cnt_q <= {LEN_BITS{1'b0}};  poll_q <= {PW{1'b0}};
         cs_q <= 1'b0;  rs_q <= 1'b0;  we_q <= 1'b0;  dout_q <= 8'h00;
         busy_q <= 1'b0;  done_q <= 1'b0;  error_q <= 1'b0;  err_addr_q <= 16'h0000;
`ifdef VDC_HOST_LOADER_VERIFY_EN
         vfy_q <= 1'b0;  shadow_q <= 8'h00;  base_q <= 16'h0000;  blen_q <= {LEN_BITS{1'b0}};
`endif
      end else begin
         state_q <= state_d;  ret_q <= ret_d;  phase_q <= phase_d;
         addr_q <= addr_d;  cnt_q <= cnt_d;  poll_q <= poll_d;
         cs_q <= cs_d;  rs_q <= rs_d;  we_q <= we_d;  dout_q <= dout_d;
         busy_q <= busy_d;  done_q <= done_d;  error_q <= error_d;  err_addr_q <= err_addr_d;
`ifdef VDC_HOST_LOADER_VERIFY_EN
         vfy_q <= vfy_d;  shadow_q <= shadow_d;  base_q <= base_d;  blen_q <= blen_d;
`endif
      end
   end

   assign vdc_cs   = cs_q;
   assign vdc_rs   = rs_q;
   assign vdc_we   = we_q;
   assign vdc_do   = dout_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign error    = error_q;
   assign err_addr = err_addr_q;

endmodule

// File: tb/tb_vdc_host_loader.sv
// Testbench for vdc_host_loader: VDC register/RAM model, stream source,
// bus scoreboard, table-driven transfers plus hand-written corner sequences.
// Also exercises VDC_HOST_LOADER_VERIFY_EN when that macro is defined.
module tb_vdc_host_loader;

   logic        clk = 1'b0;
   logic        reset, bus_en, start, start4, s_valid;
   logic [15:0] start_addr, len;
   logic [7:0]  s_data, vdc_di, vdc_di4;
   logic        vdc_cs, vdc_rs, vdc_we, s_ready, busy, done, error;
   logic [7:0]  vdc_do;
   logic [15:0] err_addr;
   logic        vdc_cs4, vdc_rs4, vdc_we4, s_ready4, busy4, done4, error4;
   logic [7:0]  vdc_do4;
   logic [15:0] err_addr4;

   always #5 clk = ~clk;

   vdc_host_loader u_dut (
      .clk(clk), .reset(reset), .bus_en(bus_en), .vdc_cs(vdc_cs), .vdc_rs(vdc_rs),
      .vdc_we(vdc_we), .vdc_do(vdc_do), .vdc_di(vdc_di), .start(start),
      .start_addr(start_addr), .len(len), .s_valid(s_valid), .s_data(s_data),
      .s_ready(s_ready), .busy(busy), .done(done), .error(error), .err_addr(err_addr));

   vdc_host_loader #(.POLL_MAX(4), .LEN_BITS(16)) u_dut4 (
      .clk(clk), .reset(reset), .bus_en(bus_en), .vdc_cs(vdc_cs4), .vdc_rs(vdc_rs4),
      .vdc_we(vdc_we4), .vdc_do(vdc_do4), .vdc_di(vdc_di4), .start(start4),
      .start_addr(start_addr), .len(len), .s_valid(s_valid), .s_data(s_data),
      .s_ready(s_ready4), .busy(busy4), .done(done4), .error(error4), .err_addr(err_addr4));

   typedef struct { logic rs; logic we; logic [7:0] d; } acc_t;
   typedef struct {
      logic [15:0] addr; int len; int nr; int stall_at; logic [31:0] dat; int exp_idle;
   } vec_t;

   acc_t        exp_q[$];
   int          n_chk = 0, n_fail = 0;
   logic [7:0]  ram [65536];
   logic [7:0]  sel_m = 8'h00;
   logic [15:0] ua_m = 16'h0000, corrupt_addr = 16'h0000;
   logic        corrupt_en = 1'b0, sb_en = 1'b1;
   logic [7:0]  data_a [4];
   int          nr_left = 0, n_data = 0, idx = 0, stall_at = 0, stall_left = 0;
   logic        stall_on = 1'b0, seen_acc = 1'b0;
   int          done_cnt = 0, idle_cnt = 0, cyc = 0;
   int          poll4_cnt = 0, rs1_4_cnt = 0, done4_cnt = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic void push(input logic rs, input logic we, input logic [7:0] d);
      acc_t a;
      a.rs = rs; a.we = we; a.d = d;
      exp_q.push_back(a);
   endfunction

   function automatic void push_setup(input logic [15:0] a);
      push(1'b0, 1'b1, 8'd18); push(1'b0, 1'b0, 8'h00); push(1'b1, 1'b1, a[15:8]);
      push(1'b0, 1'b1, 8'd19); push(1'b0, 1'b0, 8'h00); push(1'b1, 1'b1, a[7:0]);
      push(1'b0, 1'b1, 8'd31);
   endfunction

   // Input driver, VDC model, stream source and bus scoreboard
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         bus_en = (cyc % 4 != 3);
         if (vdc_cs && !vdc_rs && !vdc_we)
            vdc_di = (sel_m == 8'd31 && nr_left > 0) ? 8'h7F : 8'h80;
         else if (vdc_cs && vdc_rs && !vdc_we)
            vdc_di = ram[ua_m] ^ ((corrupt_en && ua_m == corrupt_addr) ? 8'hFF : 8'h00);
         else
            vdc_di = 8'h5A;
         if (!stall_on && stall_left > 0 && idx == stall_at && vdc_cs && !vdc_rs && !vdc_we)
            stall_on = 1'b1;
         s_valid = (n_data > 0) && !stall_on;
         s_data  = data_a[idx];
         #4;
         if (bus_en) begin
            if (stall_on) begin
               stall_left--;
               if (stall_left == 0) stall_on = 1'b0;
            end
            if (vdc_cs) begin
               seen_acc = 1'b1;
               if (sb_en) begin
                  if (exp_q.size() == 0) begin
                     n_chk++; n_fail++;
                     $display("FAIL bus_access: got rs=%0d we=%0d do=%0h, expected none", vdc_rs, vdc_we, vdc_do);
                  end else begin
                     acc_t e;
                     e = exp_q.pop_front();
                     chk("bus_access", {22'd0, vdc_rs, vdc_we, (e.we ? vdc_do : 8'h00)},
                         {22'd0, e.rs, e.we, e.d});
                  end
               end
               if (vdc_we && !vdc_rs) sel_m = vdc_do;
               else if (vdc_we) begin
                  if (sel_m == 8'd18) ua_m[15:8] = vdc_do;
                  else if (sel_m == 8'd19) ua_m[7:0] = vdc_do;
                  else if (sel_m == 8'd31) begin ram[ua_m] = vdc_do; ua_m = ua_m + 16'd1; end
               end else if (!vdc_rs) begin
                  if (sel_m == 8'd31 && nr_left > 0) nr_left--;
               end else if (sel_m == 8'd31) ua_m = ua_m + 16'd1;
            end else if (busy && seen_acc) idle_cnt++;
         end
         if (s_ready) begin
            chk("s_ready_in_slot", {31'd0, bus_en && s_valid}, 32'd1);
            idx = (idx + 1 >= n_data) ? 0 : idx + 1;
         end
         if (done) done_cnt++;
         if (bus_en && vdc_cs4) begin
            if (!vdc_rs4 && !vdc_we4) poll4_cnt++;
            if (vdc_rs4) rs1_4_cnt++;
         end
         if (done4) done4_cnt++;
      end
   end

   task automatic run_xfer(input logic [15:0] a, input int l, input int nr, input int st,
                           input logic exp_err, input logic [15:0] exp_ea, input int exp_idle);
      logic [15:0] ad;
      done_cnt = 0; idle_cnt = 0; seen_acc = 1'b0; idx = 0; n_data = l;
      nr_left = nr; stall_at = st; stall_left = (st > 0) ? 3 : 0; stall_on = 1'b0;
      exp_q.delete();
      push_setup(a);
      for (int i = 0; i < l; i++) begin
         for (int k = 0; k < ((i == 0) ? nr + 1 : 1); k++) push(1'b0, 1'b0, 8'h00);
         push(1'b1, 1'b1, data_a[i]);
      end
`ifdef VDC_HOST_LOADER_VERIFY_EN
      push_setup(a);
      for (int i = 0; i < l; i++) begin
         ad = a + 16'(i);
         push(1'b0, 1'b0, 8'h00); push(1'b1, 1'b0, 8'h00);
         if (corrupt_en && ad == corrupt_addr) break;
      end
`endif
      @(negedge clk); start = 1'b1; start_addr = a; len = 16'(l);
      @(negedge clk); start = 1'b0;
      repeat (8) @(negedge clk);
      start = 1'b1; start_addr = 16'h0BAD; len = 16'd1;   // must be ignored while busy
      @(negedge clk); start = 1'b0;
      for (int k = 0; k < 3000 && done_cnt == 0; k++) @(negedge clk);
      repeat (6) @(negedge clk);
      chk("done_once", done_cnt, 1);
      chk("busy_after", {31'd0, busy}, 32'd0);
      chk("error_flag", {31'd0, error}, {31'd0, exp_err});
      if (exp_err) chk("err_addr", {16'd0, err_addr}, {16'd0, exp_ea});
      chk("sb_drained", exp_q.size(), 0);
      chk("idle_slots", idle_cnt, exp_idle);
      for (int i = 0; i < l; i++) begin
         ad = a + 16'(i);
         chk("ram_byte", {24'd0, ram[ad]}, {24'd0, data_a[i]});
      end
   endtask

   vec_t vecs [4];

   initial begin
      vecs[0] = '{16'h1234, 3, 0, 0, 32'h00CCBBAA, 0};   // basic stream
      vecs[1] = '{16'h4000, 2, 5, 0, 32'h00002211, 0};   // 5 not-ready polls
      vecs[2] = '{16'h2000, 4, 0, 2, 32'h04030201, 3};   // 3-slot stream stall
      vecs[3] = '{16'hFFFF, 2, 0, 0, 32'h0000A55A, 0};   // address wrap
      reset = 1'b1; start = 1'b0; start4 = 1'b0; start_addr = 16'h0000; len = 16'h0000;
      vdc_di4 = 8'h7F; bus_en = 1'b0; s_valid = 1'b0; s_data = 8'h00; vdc_di = 8'h00;
      for (int i = 0; i < 4; i++) data_a[i] = 8'h00;
      for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
      repeat (3) @(negedge clk);
      #4;
      chk("reset_bus", {23'd0, vdc_cs, vdc_rs, vdc_we, vdc_do}, 32'd0);
      chk("reset_status", {28'd0, busy, done, error, s_ready}, 32'd0);
      chk("reset_err_addr", {16'd0, err_addr}, 32'd0);
      @(negedge clk); reset = 1'b0;

      // len == 0: no transfer, done on the next cycle
      @(negedge clk); start = 1'b1; start_addr = 16'h1111; len = 16'd0;
      @(negedge clk); start = 1'b0; #4;
      chk("len0_done", {30'd0, done, busy}, 32'd2);
      @(negedge clk); #4;
      chk("len0_done_pulse", {30'd0, done, busy}, 32'd0);

      for (int v = 0; v < 4; v++) begin
         for (int i = 0; i < 4; i++) data_a[i] = vecs[v].dat[8*i +: 8];
         run_xfer(vecs[v].addr, vecs[v].len, vecs[v].nr, vecs[v].stall_at,
                  1'b0, 16'h0000, vecs[v].exp_idle);
      end

      // poll timeout with POLL_MAX=4
      @(negedge clk); start4 = 1'b1; start_addr = 16'h1234; len = 16'd1;
      @(negedge clk); start4 = 1'b0;
      for (int k = 0; k < 200 && done4_cnt == 0; k++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk("to_polls", poll4_cnt, 4);
      chk("to_rs1", rs1_4_cnt, 0);
      chk("to_error", {31'd0, error4}, 32'd1);
      chk("to_err_addr", {16'd0, err_addr4}, 32'h1234);
      chk("to_done", done4_cnt, 1);
      chk("to_busy", {31'd0, busy4}, 32'd0);
      repeat (10) @(negedge clk);
      chk("to_sticky", {31'd0, error4}, 32'd1);
      start4 = 1'b1; len = 16'd0;
      @(negedge clk); start4 = 1'b0; #4;
      chk("to_cleared", {31'd0, error4}, 32'd0);

      // reset mid-transfer
      sb_en = 1'b0; n_data = 3; idx = 0; nr_left = 0; stall_left = 0;
      @(negedge clk); start = 1'b1; start_addr = 16'h3000; len = 16'd3;
      @(negedge clk); start = 1'b0;
      repeat (12) @(negedge clk);
      #4; chk("mid_busy", {31'd0, busy}, 32'd1);
      @(negedge clk); reset = 1'b1; done_cnt = 0;
      @(negedge clk); #4;
      chk("mid_reset_bus", {30'd0, vdc_cs, busy}, 32'd0);
      @(negedge clk); reset = 1'b0;
      repeat (20) @(negedge clk);
      chk("mid_no_done", done_cnt, 0);
      chk("mid_idle", {30'd0, vdc_cs, busy}, 32'd0);
      sb_en = 1'b1;

`ifdef VDC_HOST_LOADER_VERIFY_EN
      corrupt_en = 1'b1; corrupt_addr = 16'h1235;
      data_a[0] = 8'hAA; data_a[1] = 8'hBB; data_a[2] = 8'hCC; data_a[3] = 8'h00;
      run_xfer(16'h1234, 3, 0, 0, 1'b1, 16'h1235, 0);
      corrupt_en = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // Hard time limit so the bench always terminates
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected test completion");
      $fatal(1);
   end

endmodule
